char_row_renderer: RTL

- Reader side of the character-glyph ROM.
- Walks the VGA pixel coordinates across one horizontal text line of N_CHARS character cells, 8x16 pixels each.
- Drives the ROM address triple (bank select, slot, row) and serializes the returned 8-bit glyph row into a per-pixel text bit and 8-bit colour.
- Sits between the VGA sync generator and the colour mux, with one instance per text line (date, time, alarm/RING).

---
 rtl/vga_text_pkg.sv | 37 +++
 rtl/char_row_renderer_if.sv | 12 +
 rtl/char_row_renderer_glyph_code_mux.sv | 26 ++
 rtl/char_row_renderer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants for the VGA text-line renderers: cell geometry, glyph codes and colours.
package vga_text_pkg;

  localparam int CELL_W = 8;
  localparam int CELL_H = 16;
  localparam int CODE_W = 5;

  // Glyph code = {bank[2:0], slot[1:0]}; bank 0 is the blank glyph.
  localparam logic [CODE_W-1:0] GLYPH_BLANK   = 5'b000_00;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_0 = 5'b100_00;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_1 = 5'b100_01;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_2 = 5'b100_10;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_3 = 5'b100_11;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_4 = 5'b101_00;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_5 = 5'b101_01;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_6 = 5'b101_10;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_7 = 5'b101_11;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_8 = 5'b110_00;
  localparam logic [CODE_W-1:0] GLYPH_DIGIT_9 = 5'b110_01;
  localparam logic [CODE_W-1:0] GLYPH_COLON   = 5'b110_10;
  localparam logic [CODE_W-1:0] GLYPH_RING    = 5'b110_11;
  localparam logic [CODE_W-1:0] GLYPH_BALL    = 5'b111_00;
  localparam logic [CODE_W-1:0] GLYPH_SLASH   = 5'b111_01;

  localparam logic [7:0] COLOR_BLACK = 8'h00;
  localparam logic [7:0] COLOR_GREEN = 8'h1C;

  typedef struct packed {
    logic [2:0] bank;
    logic [1:0] slot;
  } glyph_addr_t;

  function automatic logic isBlinkCode(input logic [CODE_W-1:0] code);
    return (code == GLYPH_RING) || (code == GLYPH_BALL);
  endfunction

endpackage

// File: rtl/char_row_renderer_if.sv
// Glyph ROM read port: renderer drives the address triple, ROM answers combinationally.
interface char_row_renderer_if;

  logic [3:0] rom_sel;
  logic [1:0] rom_ad;
  logic [3:0] rom_lsby;
  logic [7:0] rom_data;

  modport master (output rom_sel, output rom_ad, output rom_lsby, input rom_data);
  modport slave  (input rom_sel, input rom_ad, input rom_lsby, output rom_data);

endinterface

// File: rtl/char_row_renderer_glyph_code_mux.sv
// Picks the glyph code of one cell out of the packed per-line code vector.
module glyph_code_mux
  import vga_text_pkg::*;
#(
  parameter int N_CHARS = 8,
  parameter int COL_W   = 3
) (
  input  logic [CODE_W*N_CHARS-1:0] i_text_codes,
  input  logic [COL_W-1:0]          i_col,
  output logic [CODE_W-1:0]         o_code,
  output glyph_addr_t               o_addr,
  output logic                      o_blank
);

  logic [CODE_W-1:0] w_cells [N_CHARS];

  for (genvar g = 0; g < N_CHARS; g++) begin : g_cells
    assign w_cells[g] = i_text_codes[g*CODE_W +: CODE_W];
  end

  assign o_code      = w_cells[i_col];
  assign o_addr.bank = o_code[4:2];
  assign o_addr.slot = o_code[1:0];
  assign o_blank     = (o_code[4:2] == 3'd0);

endmodule

// File: rtl/char_row_renderer.sv
// Two-stage glyph renderer for one text line: ROM address fetch, then pixel serialisation.
// Define CHAR_ROW_BLINK_EN to make the RING and ball glyphs blink 16 frames on / 16 off.
module char_row_renderer
  import vga_text_pkg::*;
#(
  parameter int         N_CHARS = 8,
  parameter int         X0      = 64,
  parameter int         Y0      = 32,
  parameter logic [7:0] FG      = 8'h1C,
  parameter logic [7:0] BG      = 8'h00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_pix_tick,
  input  logic                      i_frame_tick,
  input  logic [9:0]                i_pixel_x,
  input  logic [9:0]                i_pixel_y,
  input  logic                      i_video_on,
  input  logic [CODE_W*N_CHARS-1:0] i_text_codes,
  char_row_renderer_if.master       rom,
  output logic                      o_text_on,
  output logic [7:0]                o_rgb
);

  localparam int COL_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + CELL_W * N_CHARS);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + CELL_H);

  logic              w_hit;
  logic [9:0]        w_dx;
  logic [9:0]        w_dy;
  logic [COL_W-1:0]  w_col;
  logic [2:0]        w_bit;
  logic [3:0]        w_row;
  logic [CODE_W-1:0] w_code;
  glyph_addr_t       w_addr;
  logic              w_blank;
  logic              w_gate;
  logic              w_romBit;
  logic              w_textOnNext;
  logic              w_unused;

  logic [3:0] r_romSel;
  logic [1:0] r_romAd;
  logic [3:0] r_romLsby;
  logic       r_s1In;
  logic       r_s1Blank;
  logic [2:0] r_s1Bit;
  logic       r_s1Von;
  logic       r_s1Gate;
  logic       r_textOn;
  logic [7:0] r_rgb;

  // Bounds are checked on the raw coordinates so the subtraction below never wraps into the region.
  assign w_hit = (i_pixel_x >= X_LO) && (i_pixel_x < X_HI) &&
                 (i_pixel_y >= Y_LO) && (i_pixel_y < Y_HI);
  assign w_dx  = i_pixel_x - X_LO;
  assign w_dy  = i_pixel_y - Y_LO;
  assign w_col = w_dx[COL_W+2:3];
  assign w_bit = w_dx[2:0];
  assign w_row = w_dy[3:0];

  glyph_code_mux #(
    .N_CHARS (N_CHARS),
    .COL_W   (COL_W)
  ) u_codeMux (
    .i_text_codes (i_text_codes),
    .i_col        (w_col),
    .o_code       (w_code),
    .o_addr       (w_addr),
    .o_blank      (w_blank)
  );

`ifdef CHAR_ROW_BLINK_EN
  logic [4:0] r_frameCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameCnt <= 5'd0;
    end else if (i_frame_tick) begin
      r_frameCnt <= r_frameCnt + 5'd1;
    end
  end

  // Sampled with the pixel in stage 1, so a simultaneous frame_tick sees the old count.
  assign w_gate = ~isBlinkCode(w_code) | r_frameCnt[4];
`else
  assign w_gate = 1'b1;
`endif

  assign w_unused = ^{i_frame_tick, w_code, w_dx[9:COL_W+3], w_dy[9:4]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_romSel  <= 4'd0;
      r_romAd   <= 2'd0;
      r_romLsby <= 4'd0;
      r_s1In    <= 1'b0;
      r_s1Blank <= 1'b0;
      r_s1Bit   <= 3'd0;
      r_s1Von   <= 1'b0;
      r_s1Gate  <= 1'b0;
    end else if (i_pix_tick) begin
      if (w_hit) begin
        r_romSel  <= {1'b0, w_addr.bank};
        r_romAd   <= w_addr.slot;
        r_romLsby <= w_row;
      end
      r_s1In    <= w_hit;
      r_s1Blank <= w_blank;
      r_s1Bit   <= w_bit;
      r_s1Von   <= i_video_on;
      r_s1Gate  <= w_gate;
    end
  end

  assign w_romBit     = rom.rom_data[3'd7 - r_s1Bit];
  assign w_textOnNext = r_s1In & ~r_s1Blank & w_romBit & r_s1Gate;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_textOn <= 1'b0;
      r_rgb    <= 8'h00;
    end else if (i_pix_tick) begin
      r_textOn <= w_textOnNext;
      r_rgb    <= r_s1Von ? (w_textOnNext ? FG : BG) : 8'h00;
    end
  end

  assign rom.rom_sel  = r_romSel;
  assign rom.rom_ad   = r_romAd;
  assign rom.rom_lsby = r_romLsby;
  assign o_text_on    = r_textOn;
  assign o_rgb        = r_rgb;

endmodule
